// File: rtl/subpel_interp_stream.sv
// subpel_interp_stream
//   Streaming 8-tap sub-pixel interpolator. Accepts one row or column of
//   unsigned integer pixels and emits, for every integer position p, the
//   integer sample plus the 1/4-, 1/2- and 3/4-pel samples between p and p+1.
//   Both edges are replicated: the first pixel is replicated into the window
//   on load, and four FLUSH shifts re-insert the last pixel.
//
//   Optional feature macro: INTERP_CLAMP_EN
//     defined   : rounded results saturate to [0, 2^PIX_W-1]
//     undefined : rounded results keep their low PIX_W bits (wrap)
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       input handshake
//   in_data [PIX_W]         integer pixel
//   in_last                 final pixel of the row/column
//   out_valid/out_ready     output handshake
//   out_int [PIX_W]         integer pixel at position p
//   out_a/out_b/out_c       1/4-, 1/2-, 3/4-pel samples between p and p+1
//   out_last                final output set of the row/column
module subpel_interp_stream #(
    parameter int PIX_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_int,
    output logic [PIX_W-1:0] out_a,
    output logic [PIX_W-1:0] out_b,
    output logic [PIX_W-1:0] out_c,
    output logic             out_last
);

    localparam int ACC_W = PIX_W + 9;

    localparam int TAP_A [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    localparam int TAP_B [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int TAP_C [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state, state_nx;

    // win[0] is the oldest sample, win[7] the newest
    logic [7:0][PIX_W-1:0] win;
    logic [7:0][PIX_W-1:0] win_nx;
    logic [PIX_W-1:0]      smp;

    // Shifts since load, saturating at 3: the next shift is an emitting one
    // once three have already happened.
    logic [1:0] sh_cnt;
    logic [1:0] fl_cnt;

    logic shift_ok;
    logic accept;
    logic load;
    logic shift;
    logic emit;
    logic last_shift;

    // Signed dot product of the window with one of the three tap sets.
    function automatic logic signed [ACC_W-1:0] tap_sum(
        input logic [7:0][PIX_W-1:0] w,
        input int                    sel
    );
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] px;
        logic signed [ACC_W-1:0] cf;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            px = ACC_W'({1'b0, w[i]});
            case (sel)
                0:       cf = ACC_W'(TAP_A[i]);
                1:       cf = ACC_W'(TAP_B[i]);
                default: cf = ACC_W'(TAP_C[i]);
            endcase
            acc = acc + px * cf;
        end
        return acc;
    endfunction

    // Round half up via +32 then floor-divide by 64, then saturate or wrap.
    function automatic logic [PIX_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] sum
    );
        logic signed [ACC_W-1:0] r;
        r = (sum + ACC_W'(32)) >>> 6;
`ifdef INTERP_CLAMP_EN
        if (r < 0)
            return '0;
        else if (r > ACC_W'((1 << PIX_W) - 1))
            return '1;
        else
            return PIX_W'(r);
`else
        return PIX_W'(r);
`endif
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nx = in_last ? FLUSH : PRIME;
            end
            PRIME: begin
                if (accept) begin
                    if (in_last)
                        state_nx = FLUSH;
                    else if (sh_cnt == 2'd3)
                        state_nx = RUN;
                end
            end
            RUN: begin
                if (accept && in_last)
                    state_nx = FLUSH;
            end
            FLUSH: begin
                if (shift_ok && fl_cnt == 2'd3)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        shift_ok   = !out_valid || out_ready;
        in_ready   = shift_ok && (state != FLUSH) && !reset;
        accept     = in_valid && in_ready;
        load       = accept && (state == IDLE);
        shift      = (accept && (state != IDLE)) || ((state == FLUSH) && shift_ok);
        emit       = shift && (sh_cnt == 2'd3);
        last_shift = (state == FLUSH) && shift_ok && (fl_cnt == 2'd3);
    end

    // Window after the pending shift; outputs are computed from it so the
    // set is registered on the same edge as the shift.
    always_comb begin
        smp = (state == FLUSH) ? win[7] : in_data;
        for (int i = 0; i < 7; i++)
            win_nx[i] = win[i + 1];
        win_nx[7] = smp;
    end

    // Window / counters / registered output stage
    always_ff @(posedge clock) begin
        if (reset) begin
            win       <= '0;
            sh_cnt    <= '0;
            fl_cnt    <= '0;
            out_valid <= 1'b0;
            out_int   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                win    <= {8{in_data}};
                sh_cnt <= '0;
                fl_cnt <= '0;
            end else if (shift) begin
                win <= win_nx;
                if (sh_cnt != 2'd3)
                    sh_cnt <= sh_cnt + 2'd1;
                if (state == FLUSH)
                    fl_cnt <= fl_cnt + 2'd1;
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_int   <= win_nx[3];
                out_a     <= round_sat(tap_sum(win_nx, 0));
                out_b     <= round_sat(tap_sum(win_nx, 1));
                out_c     <= round_sat(tap_sum(win_nx, 2));
                out_last  <= last_shift;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_subpel_interp_stream.sv
// tb_subpel_interp_stream
//   Directed bench for subpel_interp_stream. A behavioural model computes every
//   expected output set from the whole row (edge replication by index clamping,
//   8-tap dot product, round-to-nearest by floor division). A single compare
//   process checks each handshaken set against the model queue and checks
//   backpressure holding. Literal expectations pin the model on the ramp, the
//   step and the single-pixel row.
module tb_subpel_interp_stream;

    localparam int PIX_W = 8;
    localparam int PMAX  = (1 << PIX_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_int;
    logic [PIX_W-1:0] out_a;
    logic [PIX_W-1:0] out_b;
    logic [PIX_W-1:0] out_c;
    logic             out_last;

    always #5 clock = ~clock;

    subpel_interp_stream #(.PIX_W(PIX_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_int  (out_int),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_last (out_last)
    );

    typedef struct {
        int vi;
        int va;
        int vb;
        int vc;
        int last;
    } set_t;

    set_t exq[$];
    int   checks = 0;
    int   errors = 0;
    int   row [16];
    int   cap_i [32];
    int   cap_a [32];
    int   cap_b [32];
    int   cap_c [32];
    int   cap_l [32];
    int   cap_n = 0;
    int   stall_cnt = 0;
    bit   held = 1'b0;
    int   h_i, h_a, h_b, h_c, h_l;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- model ----------------
    function automatic int xs(input int i, input int n);
        if (i < 0) return row[0];
        if (i > n - 1) return row[n - 1];
        return row[i];
    endfunction

    function automatic int interp(input int p, input int n, input int k);
        int ta [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
        int tb [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
        int tc [8] = '{0, 1, -5, 17, 58, -10, 4, -1};
        int s, t, r;
        s = 0;
        for (int j = 0; j < 8; j++) begin
            t = (k == 0) ? ta[j] : (k == 1) ? tb[j] : tc[j];
            s += t * xs(p - 3 + j, n);
        end
        t = s + 32;
        r = (t >= 0) ? t / 64 : -((-t + 63) / 64);
`ifdef INTERP_CLAMP_EN
        if (r < 0) r = 0;
        if (r > PMAX) r = PMAX;
`else
        r = r & PMAX;
`endif
        return r;
    endfunction

    task automatic push_row(input int n, input int pcount);
        set_t e;
        for (int p = 0; p < pcount; p++) begin
            e.vi   = xs(p, n);
            e.va   = interp(p, n, 0);
            e.vb   = interp(p, n, 1);
            e.vc   = interp(p, n, 2);
            e.last = (pcount == n && p == n - 1) ? 1 : 0;
            exq.push_back(e);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        set_t e;
        if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_int", out_int, h_i);
            check("hold_a", out_a, h_a);
            check("hold_b", out_b, h_b);
            check("hold_c", out_c, h_c);
            check("hold_last", out_last, h_l);
        end
        if (out_valid && !out_ready && !reset) begin
            check("bp_in_ready", in_ready, 0);
            stall_cnt++;
            held = 1'b1;
            h_i = out_int; h_a = out_a; h_b = out_b; h_c = out_c; h_l = out_last;
        end else begin
            held = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (exq.size() == 0) begin
                check("unexpected_set", 1, 0);
            end else begin
                e = exq.pop_front();
                check("set_int", out_int, e.vi);
                check("set_a", out_a, e.va);
                check("set_b", out_b, e.vb);
                check("set_c", out_c, e.vc);
                check("set_last", out_last, e.last);
            end
            if (cap_n < 32) begin
                cap_i[cap_n] = out_int; cap_a[cap_n] = out_a;
                cap_b[cap_n] = out_b;   cap_c[cap_n] = out_c;
                cap_l[cap_n] = out_last;
            end
            cap_n++;
        end
    end

    // ---------------- driver ----------------
    task automatic send_pix(input int v, input bit last);
        int t;
        in_valid = 1'b1;
        in_data  = PIX_W'(v);
        in_last  = last;
        t = 0;
        @(negedge clock);
        while (!in_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) check("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exq.size() != 0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (t >= 300) check("drain_timeout", exq.size(), 0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_row(input int n);
        cap_n = 0;
        push_row(n, n);
        for (int i = 0; i < n; i++)
            send_pix(row[i], (i == n - 1));
        drain();
        check("row_sets", cap_n, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_int", out_int, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_c", out_c, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_in_ready", in_ready, 1);

        // constant row
        for (int i = 0; i < 16; i++) row[i] = 100;
        send_row(16);
        check("const_a7", cap_a[7], 100);
        check("const_c0", cap_c[0], 100);
        check("const_last14", cap_l[14], 0);
        check("const_last15", cap_l[15], 1);

        // ramp
        for (int i = 0; i < 16; i++) row[i] = 8 * i;
        send_row(16);
        check("ramp_int5", cap_i[5], 40);
        check("ramp_a5", cap_a[5], 42);
        check("ramp_b5", cap_b[5], 44);
        check("ramp_c5", cap_c[5], 46);
        for (int p = 3; p <= 11; p++) begin
            check("ramp_a_p", cap_a[p], 8 * p + 2);
            check("ramp_b_p", cap_b[p], 8 * p + 4);
            check("ramp_c_p", cap_c[p], 8 * p + 6);
        end

        // step
        for (int i = 0; i < 8; i++) row[i] = (i < 4) ? 0 : 255;
        send_row(8);
        check("step_c3", cap_c[3], 203);
`ifdef INTERP_CLAMP_EN
        check("step_a4", cap_a[4], 255);
        check("step_b2", cap_b[2], 0);
`else
        check("step_a4", cap_a[4], 27);
        check("step_b2", cap_b[2], 224);
`endif

        // backpressure mid-row
        for (int i = 0; i < 16; i++) row[i] = 8 * i;
        stall_cnt = 0;
        fork
            send_row(16);
            begin
                repeat (8) @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_stalls", stall_cnt, 3);

        // single-pixel row
        row[0] = 77;
        cap_n = 0;
        push_row(1, 1);
        send_pix(77, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("flush_in_ready", in_ready, 0);
            check("flush_out_valid", out_valid, 0);
        end
        @(negedge clock);
        check("n1_valid", out_valid, 1);
        check("n1_last", out_last, 1);
        check("n1_int", out_int, 77);
        check("n1_a", out_a, 77);
        check("n1_b", out_b, 77);
        check("n1_c", out_c, 77);
        check("n1_idle_ready", in_ready, 1);
        @(posedge clock);
        #1;
        drain();
        check("n1_sets", cap_n, 1);

        // reset mid-row after 6 pixels
        for (int i = 0; i < 16; i++) row[i] = 8 * i + 3;
        cap_n = 0;
        push_row(16, 2);
        for (int i = 0; i < 6; i++) send_pix(row[i], 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_sets", cap_n, 2);
        check("midrst_queue", exq.size(), 0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) row[i] = 8 * i;
        send_row(16);
        check("fresh_b5", cap_b[5], 44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subpel_interp_stream.md
# subpel_interp_stream

Streaming 8-tap sub-pixel interpolator: the parametrised successor to the fixed 8-bit row/column interpolator in the approximate-computing datapath. It accepts one row or column of integer pixels over a valid/ready handshake. Edges are replicated internally. For every integer position it emits the integer sample plus the quarter-, half- and three-quarter-pel samples. Output is rounded and optionally clamped. The block sits between the frame-buffer reader and the sub-pixel store, and is reused for the horizontal pass and the vertical (second) pass.

## Interface
- PIX_W, 8, pixel width in bits (4..12)
- ACC_W, PIX_W+9, signed accumulator width; derived, not overridden
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts the pixel this cycle
- in_data  in  PIX_W  unsigned integer pixel
- in_last  in  1  marks the final pixel of the current row/column
- out_valid  out  1  output sample set valid
- out_ready  in  1  downstream accepts
- out_int  out  PIX_W  integer pixel at position p
- out_a / out_b / out_c  out  PIX_W  1/4-, 1/2- and 3/4-pel samples between p and p+1
- out_last  out  1  set on the final output set of the row

## Operation
- Window: 8-entry shift register w[0..7]. Each shift moves w[7] into w[6], and so on; the new sample enters w[7]. Output for position p is computed when w[3]=x_p and w[7]=x_{p+4}.
- Taps, applied to w[0..7]:
  - a: -1,4,-10,58,17,-5,1,0
  - b: -1,4,-11,40,40,-11,4,-1
  - c: 0,1,-5,17,58,-10,4,-1
  - Each tap set sums to 64.
- Arithmetic: signed ACC_W sum, then (sum+32)>>>6 (arithmetic shift, floor). out_int = w[3].
- shift_ok = !out_valid || out_ready.
- in_ready = shift_ok && state ∈ {IDLE, PRIME, RUN}. It is 0 while reset is high.
- FSM:
  - IDLE: on the first accept, load all 8 entries with x0 and set shift count to 0. If in_last=1, go to FLUSH; otherwise go to PRIME.
  - PRIME: each accept shifts and increments the count. The 4th shift emits an output and moves to RUN. An accept with in_last=1 goes to FLUSH.
  - RUN: each accept shifts and emits. An accept with in_last=1 goes to FLUSH.
  - FLUSH: exactly 4 shifts of the replicated last pixel, each taken when shift_ok is high. After the 4th, return to IDLE.
- Emission: shifts are numbered 1.. from the load. Only shifts numbered ≥4 emit (register the outputs, set out_valid). A row of N pixels (N≥1) therefore produces exactly N output sets. out_last is set on the final FLUSH shift.
- out_valid clears on an out_ready handshake unless a new emit occurs in the same cycle.
- Reset mid-row: the partial row is discarded. State returns to IDLE, the window clears, and no out_last is produced.

## Timing
- Reset values: out_valid=0, out_int/a/b/c=0, out_last=0, state=IDLE, window=0.
- Latency: the output set for x_p is valid the cycle after x_{p+4} is accepted, or after the corresponding FLUSH shift.
- Throughput: 1 pixel/cycle sustained with out_ready held high.
- Per-row overhead: 4 FLUSH cycles. IDLE can accept the next row's first pixel the cycle after the last FLUSH shift.
- Backpressure: with out_valid=1 and out_ready=0, the outputs hold stable, no shift occurs, and in_ready=0 (FLUSH also stalls).
- When out_valid=1 and out_ready=1 and a shift also occurs in the same cycle, the new set replaces the old with no bubble.

## Configuration
- INTERP_CLAMP_EN defined: the rounded result saturates to [0, 2^PIX_W-1].
- INTERP_CLAMP_EN undefined: output is the rounded result [PIX_W-1:0], which wraps (legacy approximate behaviour). out_int is unaffected in both cases.

## Test plan
- Constant row, N=16, every pixel 100 -> 16 sets, all fields 100; out_last only on the 16th.
- Ramp x_i=8i, N=16 -> at p=5: int=40, a=42, b=44, c=46. Same +8 pattern for each interior p in 3..11.
- Step 0,0,0,0,255,255,255,255 (N=8), clamp enabled:
  - p=3: c=203
  - p=4: a=255 (raw 283)
  - p=2: b=0 (raw -32)
  - Same row with clamp disabled -> a=27, b=224.
- Backpressure: out_ready=0 for 3 cycles mid-row, N=16 ramp -> outputs held stable, in_ready=0, no lost or duplicated sets, 16 total.
- N=1, x0=77 with in_last on the first pixel -> exactly one set (77,77,77,77) with out_last=1, 4 FLUSH cycles, then IDLE.
- Reset asserted for 1 cycle after 6 pixels of a row -> out_valid=0 the next cycle. A fresh 16-pixel row then yields exactly 16 correct sets.
